// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_pkg
// Description : Shared state encoding, stage indices and the stall/flush
//               patterns used by the pipeline hazard controller.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

  // Controller state: normal issue or waiting on a multi-cycle divide
  typedef enum logic [0:0] {
    S_RUN = 1'b0,
    S_DIV = 1'b1
  } state_t;

  // Bit position of each pipeline register in the stall/flush vectors
  localparam int STG_PC  = 0;
  localparam int STG_IF  = 1;
  localparam int STG_ID  = 2;
  localparam int STG_EX  = 3;
  localparam int STG_WB  = 4;

  // Data-bus wait: freeze PC..EX/MEM, bubble into MEM/WB
  localparam logic [4:0] STALL_BUS  = 5'b01111;
  localparam logic [4:0] FLUSH_BUS  = 5'b10000;
  // Taken jump resolved in EX: squash the two younger instructions
  localparam logic [4:0] FLUSH_JUMP = 5'b00110;
  // Interrupt entry: squash everything not yet past EX/MEM
  localparam logic [4:0] FLUSH_INT  = 5'b01110;
  // Divide in flight: hold PC..ID/EX, bubble into EX/MEM
  localparam logic [4:0] STALL_DIV  = 5'b00111;
  localparam logic [4:0] FLUSH_DIV  = 5'b01000;
  // Load-use: hold PC and IF/ID, bubble into ID/EX
  localparam logic [4:0] STALL_LU   = 5'b00011;
  localparam logic [4:0] FLUSH_LU   = 5'b00100;

endpackage
`default_nettype wire

// File: rtl/pipe_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_if
// Description : Hazard request / pipeline control bundle between the core
//               datapath (master) and the hazard controller (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface pipe_ctrl_if #(
  parameter int AW    = 32,
  parameter int CNT_W = 32
);
  // Hazard requests from the datapath
  logic          loadUseReq;
  logic          exJumpReq;
  logic [AW-1:0] exJumpAddr;
  logic          divStart;
  logic          divDone;
  logic          busReq;
  logic          busGrant;
  logic          intReq;
  logic [AW-1:0] intAddr;
  // Pipeline controls back to the datapath
  logic [4:0]       stall;
  logic [4:0]       flush;
  logic             jumpFlag;
  logic [AW-1:0]    jumpAddr;
  logic             intAck;
  logic             divTimeout;
  logic [CNT_W-1:0] perfStallCnt;

  modport master (
    output loadUseReq, exJumpReq, exJumpAddr, divStart, divDone,
           busReq, busGrant, intReq, intAddr,
    input  stall, flush, jumpFlag, jumpAddr, intAck, divTimeout, perfStallCnt
  );

  modport slave (
    input  loadUseReq, exJumpReq, exJumpAddr, divStart, divDone,
           busReq, busGrant, intReq, intAddr,
    output stall, flush, jumpFlag, jumpAddr, intAck, divTimeout, perfStallCnt
  );
endinterface
`default_nettype wire

// File: rtl/pipe_stall_cnt.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stall_cnt
// Description : Saturating event counter; sticks at all-ones.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stall_cnt #(
  parameter int CNT_W = 32
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             i_inc,
  output logic      [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next value: increment when enabled unless already saturated
  always_comb begin
    count_d = count_q;
    if (i_inc && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_count = count_q;

endmodule
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl
// Description : Pipeline hazard / flush controller for the 5-stage core.
//               Arbitrates bus wait, EX jumps, interrupts, divide wait and
//               load-use hazards into per-register stall/flush controls.
//               Optional macro PIPE_CTRL_INT_EN compiles in the interrupt path.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl #(
  parameter int AW          = 32,
  parameter int DIV_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  wire logic   clk,
  input  wire logic   rst,
  pipe_ctrl_if.slave  bus
);
  import pipe_ctrl_pkg::*;

  localparam int DIV_CW = (DIV_TIMEOUT > 1) ? $clog2(DIV_TIMEOUT) : 1;
  localparam logic [DIV_CW-1:0] C_DIV_LAST = DIV_CW'(DIV_TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [DIV_CW-1:0] div_cnt_q, div_cnt_d;
  logic              div_timeout_q, div_timeout_d;

  logic              w_bus_wait;
  logic              w_int_take;
  logic [AW-1:0]     w_int_addr;
  logic [4:0]        w_stall;
  logic [4:0]        w_flush;
  logic              w_jump_flag;
  logic [AW-1:0]     w_jump_addr;
  logic              w_int_ack;

  assign w_bus_wait = bus.busReq && !bus.busGrant;

`ifdef PIPE_CTRL_INT_EN
  logic int_lock_q, int_lock_d;

  // Interrupt is taken once per high level of intReq
  assign w_int_take = bus.intReq && !int_lock_q;
  assign w_int_addr = bus.intAddr;

  // Lock set after an acknowledge, released once the request is seen low
  always_comb begin
    int_lock_d = w_int_ack || (int_lock_q && bus.intReq);
  end

  // Interrupt lock register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      int_lock_q <= 1'b0;
    end else begin
      int_lock_q <= int_lock_d;
    end
  end
`else
  logic unused_int;

  assign w_int_take = 1'b0;
  assign w_int_addr = '0;
  assign unused_int = bus.intReq ^ (^bus.intAddr);
`endif

  // Hazard arbitration, next state and divide counter
  always_comb begin
    w_stall       = '0;
    w_flush       = '0;
    w_jump_flag   = 1'b0;
    w_jump_addr   = '0;
    w_int_ack     = 1'b0;
    state_d       = state_q;
    div_cnt_d     = div_cnt_q;
    div_timeout_d = 1'b0;

    if (w_bus_wait) begin
      // Whole front of the pipe freezes; state and divide count hold
      w_stall = STALL_BUS;
      w_flush = FLUSH_BUS;
    end else if (state_q == S_RUN) begin
      if (bus.exJumpReq) begin
        w_flush     = FLUSH_JUMP;
        w_jump_flag = 1'b1;
        w_jump_addr = bus.exJumpAddr;
      end else if (w_int_take) begin
        w_flush     = FLUSH_INT;
        w_jump_flag = 1'b1;
        w_jump_addr = w_int_addr;
        w_int_ack   = 1'b1;
      end else if (bus.loadUseReq) begin
        w_stall = STALL_LU;
        w_flush = FLUSH_LU;
      end
      // A divide finishing in its issue cycle never enters the wait state
      if (bus.divStart && !bus.divDone) begin
        state_d   = S_DIV;
        div_cnt_d = '0;
      end
    end else begin
      if (bus.divDone) begin
        // Result advances this cycle, so no stall
        state_d = S_RUN;
      end else begin
        w_stall = STALL_DIV;
        w_flush = FLUSH_DIV;
        if (div_cnt_q == C_DIV_LAST) begin
          state_d       = S_RUN;
          div_timeout_d = 1'b1;
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
    end
  end

  // Controller state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_RUN;
      div_cnt_q     <= '0;
      div_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      div_cnt_q     <= div_cnt_d;
      div_timeout_q <= div_timeout_d;
    end
  end

  pipe_stall_cnt #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (|w_stall),
    .o_count (bus.perfStallCnt)
  );

  assign bus.stall      = w_stall;
  assign bus.flush      = w_flush;
  assign bus.jumpFlag   = w_jump_flag;
  assign bus.jumpAddr   = w_jump_addr;
  assign bus.intAck     = w_int_ack;
  assign bus.divTimeout = div_timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_ctrl
// Description : Self-checking bench for pipe_ctrl: cycle model plus directed
//               vectors with literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl;

  localparam int AW          = 32;
  localparam int DIV_TIMEOUT = 64;
  localparam int CNT_W       = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int checks = 0;
  int errors = 0;

  pipe_ctrl_if #(.AW(AW), .CNT_W(CNT_W)) bus ();

  pipe_ctrl #(
    .AW          (AW),
    .DIV_TIMEOUT (DIV_TIMEOUT),
    .CNT_W       (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit      m_div;
  int      m_waited;
  bit      m_lock;
  longint  m_perf;
  bit      m_to;

  always @(negedge clk) begin
    logic [4:0]    e_stall, e_flush;
    logic          e_jf, e_ack, e_to_next;
    logic [AW-1:0] e_ja;
    if (rst) begin
      m_div = 0; m_waited = 0; m_lock = 0; m_perf = 0; m_to = 0;
      chk("rst_stall", bus.stall, 0);
      chk("rst_flush", bus.flush, 0);
      chk("rst_perf", bus.perfStallCnt, 0);
      chk("rst_divTimeout", bus.divTimeout, 0);
    end else begin
      e_stall = 0; e_flush = 0; e_jf = 0; e_ja = 0; e_ack = 0; e_to_next = 0;
      if (bus.busReq && !bus.busGrant) begin
        e_stall = 5'b01111; e_flush = 5'b10000;
      end else if (!m_div) begin
        if (bus.exJumpReq) begin
          e_flush = 5'b00110; e_jf = 1; e_ja = bus.exJumpAddr;
        end
`ifdef PIPE_CTRL_INT_EN
        else if (bus.intReq && !m_lock) begin
          e_flush = 5'b01110; e_jf = 1; e_ja = bus.intAddr; e_ack = 1;
        end
`endif
        else if (bus.loadUseReq) begin
          e_stall = 5'b00011; e_flush = 5'b00100;
        end
        if (bus.divStart && !bus.divDone) begin
          m_div = 1; m_waited = 0;
        end
      end else if (bus.divDone) begin
        m_div = 0;
      end else begin
        e_stall = 5'b00111; e_flush = 5'b01000;
        m_waited++;
        if (m_waited == DIV_TIMEOUT) begin
          m_div = 0; e_to_next = 1;
        end
      end
      chk("stall", bus.stall, e_stall);
      chk("flush", bus.flush, e_flush);
      chk("jumpFlag", bus.jumpFlag, e_jf);
      chk("jumpAddr", bus.jumpAddr, e_ja);
      chk("intAck", bus.intAck, e_ack);
      chk("divTimeout", bus.divTimeout, m_to);
      chk("perfStallCnt", bus.perfStallCnt, m_perf);
      if (e_stall != 0 && m_perf < 64'hFFFF_FFFF) m_perf++;
      if (e_ack) m_lock = 1;
      else if (!bus.intReq) m_lock = 0;
      m_to = e_to_next;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic clear_inputs();
    bus.loadUseReq = 0; bus.exJumpReq = 0; bus.exJumpAddr = 0;
    bus.divStart = 0; bus.divDone = 0; bus.busReq = 0; bus.busGrant = 0;
    bus.intReq = 0; bus.intAddr = 0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1;
    clear_inputs();
    @(negedge clk);
    chk("reset_jumpAddr", bus.jumpAddr, 0);
    chk("reset_intAck", bus.intAck, 0);
    step();
    rst = 0;
  endtask

  initial begin
    int n;
    int acks;
    clear_inputs();
    repeat (2) @(negedge clk);
    do_reset();

    // Load-use: one cycle of stall/bubble, then clear
    bus.loadUseReq = 1;
    @(negedge clk);
    chk("lu_stall", bus.stall, 5'b00011);
    chk("lu_flush", bus.flush, 5'b00100);
    step(); bus.loadUseReq = 0;
    @(negedge clk);
    chk("lu_after_stall", bus.stall, 0);
    step();

    // Jump overrides concurrent load-use
    bus.exJumpReq = 1; bus.exJumpAddr = 32'h80; bus.loadUseReq = 1;
    @(negedge clk);
    chk("jmp_flag", bus.jumpFlag, 1);
    chk("jmp_addr", bus.jumpAddr, 32'h80);
    chk("jmp_flush", bus.flush, 5'b00110);
    chk("jmp_stall", bus.stall, 0);
    step(); clear_inputs();

    // Bus granted in the request cycle: no stall
    bus.busReq = 1; bus.busGrant = 1;
    @(negedge clk);
    chk("bus_grant_stall", bus.stall, 0);
    step(); clear_inputs();

    // Zero-latency divide
    bus.divStart = 1; bus.divDone = 1;
    step(); clear_inputs();
    @(negedge clk);
    chk("div0_stall", bus.stall, 0);
    step();

    // Divide completing after 5 wait cycles
    do_reset();
    bus.divStart = 1;
    @(negedge clk);
    chk("div_issue_stall", bus.stall, 0);
    step(); bus.divStart = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("div_wait_stall", bus.stall, 5'b00111);
      step();
    end
    bus.divDone = 1;
    @(negedge clk);
    chk("div_done_stall", bus.stall, 0);
    step(); bus.divDone = 0;
    @(negedge clk);
    chk("div_perf", bus.perfStallCnt, 5);
    chk("div_done_run", bus.stall, 0);
    step();

    // Divide timeout
    do_reset();
    bus.divStart = 1;
    step(); bus.divStart = 0;
    for (int i = 0; i < DIV_TIMEOUT; i++) begin
      @(negedge clk);
      if (bus.stall !== 5'b00111) chk("to_wait_stall", bus.stall, 5'b00111);
      step();
    end
    @(negedge clk);
    chk("to_stall_clear", bus.stall, 0);
    chk("to_pulse", bus.divTimeout, 1);
    chk("to_perf", bus.perfStallCnt, 64);
    step();
    @(negedge clk);
    chk("to_pulse_end", bus.divTimeout, 0);
    step();

    // Bus wait in the middle of a divide freezes the divide count
    do_reset();
    bus.divStart = 1;
    step(); bus.divStart = 0;
    repeat (2) step();
    bus.busReq = 1; bus.busGrant = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bw_stall", bus.stall, 5'b01111);
      chk("bw_flush", bus.flush, 5'b10000);
      step();
    end
    bus.busReq = 0;
    n = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus.stall !== 5'b00111) break;
      n++;
      step();
    end
    chk("bw_resume_cycles", n, DIV_TIMEOUT - 2);
    chk("bw_timeout_pulse", bus.divTimeout, 1);
    step();

    // Interrupt level held for 10 cycles
    do_reset();
    bus.intReq = 1; bus.intAddr = 32'h1234;
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.intAck === 1'b1) acks++;
`ifdef PIPE_CTRL_INT_EN
      if (i == 0) begin
        chk("int_addr", bus.jumpAddr, 32'h1234);
        chk("int_flush", bus.flush, 5'b01110);
      end
`endif
      step();
    end
    clear_inputs();
`ifdef PIPE_CTRL_INT_EN
    chk("int_ack_count", acks, 1);
`else
    chk("int_ack_count", acks, 0);
`endif
    step();

    // Reset asserted mid-divide aborts it
    do_reset();
    bus.divStart = 1;
    step(); bus.divStart = 0;
    repeat (3) step();
    #2 rst = 1;
    @(negedge clk);
    chk("mid_rst_stall", bus.stall, 0);
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("post_rst_stall", bus.stall, 0);
    chk("post_rst_flush", bus.flush, 0);
    step();
    @(negedge clk);
    chk("post_rst_run", bus.stall, 0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline hazard and flush controller for the 5-stage core. It generates per-register stall and flush controls for the pipeline registers and the PC register. Flush drives each register's hold/set input, which loads that register's bubble value. Stall gates the register's input so it keeps its value. It arbitrates load-use hazards, EX-stage jumps, multi-cycle divide, data-bus wait and external interrupts, and keeps a stall-cycle performance counter.

## Interface
- AW, 32, jump/interrupt address width
- DIV_TIMEOUT, 64, maximum cycles in divide wait before forced release
- CNT_W, 32, performance counter width
- clk  input  1  core clock
- rst  input  1  asynchronous, active-high reset
- loadUseReq  input  1  ID source register matches a load's rd in EX
- exJumpReq  input  1  EX resolves a taken branch/jump
- exJumpAddr  input  AW  target of exJumpReq
- divStart  input  1  EX issues a divide (one-cycle pulse)
- divDone  input  1  divider result valid (one-cycle pulse)
- busReq  input  1  MEM stage data-bus access active
- busGrant  input  1  data bus completes access this cycle
- intReq  input  1  external interrupt request (level)
- intAddr  input  AW  interrupt vector
- stall  output  5  hold stage register; bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB
- flush  output  5  load bubble into stage register, same bit order
- jumpFlag  output  1  PC load this cycle
- jumpAddr  output  AW  PC load value
- intAck  output  1  interrupt taken (one-cycle pulse)
- divTimeout  output  1  registered one-cycle pulse on divide timeout
- perfStallCnt  output  CNT_W  cycles with any stall bit set

## Operation
- States: S_RUN, S_DIV. Reset → S_RUN.
- stall, flush, jumpFlag, jumpAddr and intAck are combinational from state and inputs. When none of the cases below applies, they are all 0.
- Priority, highest first:
  1. Bus wait, when busReq && !busGrant in any state: stall=5'b01111, flush=5'b10000. No other action is taken this cycle. State and divide counter hold.
  2. Jump, in S_RUN with exJumpReq: flush=5'b00110, jumpFlag=1, jumpAddr=exJumpAddr. A concurrent loadUseReq is ignored.
  3. Interrupt, in S_RUN with intReq && !intLock and no stall this cycle: flush=5'b01110, jumpFlag=1, jumpAddr=intAddr, intAck=1. intLock is set next cycle and cleared the cycle after intReq is seen low (level-to-pulse).
  4. Divide wait, in S_DIV without divDone: stall=5'b00111, flush=5'b01000.
  5. Load-use, in S_RUN with loadUseReq: stall=5'b00011, flush=5'b00100. Lasts one cycle.
- Divide transitions:
  - S_RUN with divStart and no bus wait → S_DIV, divCnt=0. The divStart cycle itself does not stall.
  - S_DIV with divDone → S_RUN. No stall in that cycle, so the result advances.
  - S_DIV increments divCnt each non-bus-wait cycle. At divCnt==DIV_TIMEOUT-1 without divDone → S_RUN and divTimeout=1 next cycle.
- exJumpReq, loadUseReq and intReq are ignored in S_DIV.
- perfStallCnt increments when |stall is 1. It saturates at all-ones.

## Timing
- Combinational outputs take effect at the same clk edge that samples the inputs. Flush/stall registers update at that edge.
- Reset values: stall=0, flush=0, jumpFlag=0, jumpAddr=0, intAck=0, divTimeout=0, perfStallCnt=0. Internally divCnt=0, intLock=0, state=S_RUN.
- Reset asserted mid-divide or mid-bus-wait aborts immediately. The next cycle after release is S_RUN with no stall.
- divStart and divDone in the same cycle in S_RUN: remain in S_RUN, no stall (zero-latency divide).
- busGrant in the same cycle as busReq: no stall.

## Configuration
- PIPE_CTRL_INT_EN defined: interrupt path compiled in as described.
- PIPE_CTRL_INT_EN undefined: intReq and intAddr are ignored, intAck is tied 0, and the intLock flop is removed. All other behaviour is unchanged.

## Structure
- Shared package pipe_ctrl_pkg holds:
  - state encoding (S_RUN=1'b0, S_DIV=1'b1)
  - stage index constants STG_PC..STG_WB (0..4)
  - constant stall/flush patterns for each hazard class
- One sub-module, pipe_stall_cnt: saturating CNT_W counter with async reset and increment enable.

## Test plan
- Reset, then loadUseReq=1 for one cycle → stall=00011, flush=00100 for exactly that cycle, then 0.
- exJumpReq=1, exJumpAddr=0x80, with loadUseReq=1 → jumpFlag=1, jumpAddr=0x80, flush=00110, stall=0.
- divStart, then divDone after 5 cycles → stall=00111 for 5 cycles, state S_RUN on divDone cycle, perfStallCnt=5.
- divStart and no divDone with DIV_TIMEOUT=64 → stall for 64 cycles, then divTimeout pulses once and stall clears.
- busReq=1, busGrant=0 for 3 cycles during S_DIV → stall=01111 for 3 cycles, divCnt frozen, divide wait resumes afterwards.
- intReq held high for 10 cycles with PIPE_CTRL_INT_EN → single intAck pulse, jumpAddr=intAddr. Without the macro → intAck never asserts.
